// File: rtl/hann_frame_ctrl_if.sv
// Signal bundle between the Hann frame sequencer and its sample source, coefficient ROM and sink.
// master = environment side, slave = sequencer side.
interface hann_frame_ctrl_if #(
    parameter int DW = 12,
    parameter int CW = 12,
    parameter int IW = 6
);
    logic          start;
    logic          abort;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [IW-1:0] coef_idx;
    logic [CW-1:0] coef;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sop;
    logic          m_eop;
    logic          busy;
    logic          done;
    logic [7:0]    frame_cnt;

    modport master (
        output start, abort, s_data, s_valid, coef, m_ready,
        input  s_ready, coef_idx, m_data, m_valid, m_sop, m_eop, busy, done, frame_cnt
    );

    modport slave (
        input  start, abort, s_data, s_valid, coef, m_ready,
        output s_ready, coef_idx, m_data, m_valid, m_sop, m_eop, busy, done, frame_cnt
    );
endinterface

// File: rtl/hann_frame_ctrl.sv
// Windows one N-sample frame per start: sample x coef(k), Q11 round, 1-cycle latency to m_valid.
// Backpressure: a stalled output (m_valid && !m_ready) drops s_ready; k and coef_idx hold.
module hann_frame_ctrl #(
    parameter int N  = 32,
    parameter int DW = 12,
    parameter int CW = 12,
    parameter int IW = 6
) (
    input  logic             clk,
    input  logic             rst,
    hann_frame_ctrl_if.slave bus
);
    localparam int            PW     = DW + CW + 1;
    localparam int            FRAC   = CW - 1;
    localparam logic [IW-1:0] K_LAST = IW'(N - 1);
    localparam logic [PW-1:0] BIAS   = PW'(1) << (FRAC - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] k;
    logic          ready;
    logic          acc;
    logic          fin;
    logic          m_valid_q;
    logic          m_sop_q;
    logic          m_eop_q;
    logic [DW-1:0] m_data_q;
    logic [7:0]    frame_cnt_q;
    logic [PW-1:0] prod;
    logic [PW-1:0] prod_rnd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = PRIME;
            PRIME: state_nxt = RUN;
            RUN: begin
                ready = !m_valid_q || bus.m_ready;
                if (bus.s_valid && ready && (k == K_LAST)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (m_valid_q && bus.m_ready) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // abort wins over everything, including a start in IDLE
        if (bus.abort) begin
            state_nxt = IDLE;
            ready     = 1'b0;
            fin       = 1'b0;
        end
    end

    assign acc = bus.s_valid && ready;

    // k is already 0 whenever the FSM sits in IDLE, so start needs no explicit clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   k <= '0;
        else if (bus.abort || fin) k <= '0;
        else if (acc)              k <= k + 1'b1;
    end

    // Look one index ahead on accept so the registered ROM delivers coef(k) every RUN cycle
    assign bus.coef_idx = acc ? k + 1'b1 : k;

    assign prod     = {{(PW-DW){bus.s_data[DW-1]}}, bus.s_data} * {{(PW-CW){1'b0}}, bus.coef};
    assign prod_rnd = prod + BIAS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_sop_q   <= 1'b0;
            m_eop_q   <= 1'b0;
            m_data_q  <= '0;
        end else if (bus.abort) begin
            m_valid_q <= 1'b0;
        end else if (acc) begin
            m_valid_q <= 1'b1;
            m_sop_q   <= (k == '0);
            m_eop_q   <= (k == K_LAST);
            m_data_q  <= DW'(prod_rnd >> FRAC);
        end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      frame_cnt_q <= '0;
        else if (fin) frame_cnt_q <= frame_cnt_q + 8'd1;
    end

    assign bus.s_ready   = ready;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_sop     = m_sop_q;
    assign bus.m_eop     = m_eop_q;
    assign bus.m_data    = m_data_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = fin;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: doc/hann_frame_ctrl.md
# hann_frame_ctrl

Frame sequencer for the 32-point Hann window coefficient source. On `start` it primes the coefficient index, accepts exactly N input samples over a valid/ready stream, and multiplies each sample by its window coefficient. The windowed samples go out with start-of-frame and end-of-frame markers. The block sits between the sample capture stream and the FFT/spectral stage, and it is the only driver of the coefficient index.

## Interface
- `N`, 32: samples per frame; coefficient index range 0..N-1; N ≤ 63.
- `DW`, 12: signed sample width, in and out.
- `CW`, 12: unsigned coefficient width, Q11 format (2047 ≈ 1.0).
- `IW`, 6: coefficient index width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: frame request pulse; ignored while `busy`.
- `abort` in 1: cancels the current frame; has priority over `start`.
- `s_data` in DW: signed input sample.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: block accepts `s_data` this cycle.
- `coef_idx` out IW: index presented to the registered coefficient source.
- `coef` in CW: coefficient for the `coef_idx` of the previous cycle (1-cycle registered lookup).
- `m_data` out DW: windowed sample.
- `m_valid` out 1: output valid.
- `m_ready` in 1: downstream accepts.
- `m_sop` out 1: marks index 0; qualified by `m_valid`.
- `m_eop` out 1: marks index N-1; qualified by `m_valid`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse on normal frame completion.
- `frame_cnt` out 8: count of completed frames; wraps 255→0.

## Operation
- States:
  - IDLE: default state.
  - PRIME: exactly 1 cycle; lets `coef` settle for index 0.
  - RUN: accepts samples.
  - DRAIN: waits for the last output to be taken.
- Transitions:
  - IDLE→PRIME on `start` && !`abort`; k (next index) set to 0.
  - PRIME→RUN unconditionally.
  - RUN→DRAIN on the cycle the N-th sample (k = N-1) is accepted.
  - DRAIN→IDLE when `m_valid` && `m_ready`; `done` pulses in that same cycle and `frame_cnt` increments.
- Input handshake:
  - `s_ready` = (state == RUN) && (!`m_valid` || `m_ready`).
  - acc = `s_valid` && `s_ready`.
  - On acc, k increments.
- Coefficient lookahead:
  - `coef_idx` = acc ? k+1 : k (combinational).
  - Outside RUN/PRIME, `coef_idx` = k.
  - Result: `coef` equals coef(k) in every RUN cycle, so throughput is 1 sample/cycle.
- Arithmetic:
  - p = signed(`s_data`) × unsigned(`coef`), 24-bit signed.
  - `m_data` = (p + 1024) >>> 11 (arithmetic shift, floor after +0.5 bias).
  - No saturation is needed: |result| ≤ 2047.
- Output register:
  - On acc, load `m_data`, set `m_valid`, `m_sop` = (k == 0), `m_eop` = (k == N-1).
  - Otherwise, if `m_ready`, clear `m_valid`.
  - `m_data`, `m_sop` and `m_eop` hold while `m_valid` && !`m_ready`.
- Abort, from any state:
  - Next state is IDLE.
  - `m_valid` is cleared, k = 0, `s_ready` is low.
  - No `done`; `frame_cnt` unchanged.
- `start` while `busy` is dropped, not queued.
- `start` on the cycle DRAIN→IDLE is also dropped. The earliest accepted restart is the cycle after `done`.

## Timing
- Reset values:
  - state IDLE, k 0, `coef_idx` 0.
  - `s_ready`, `m_valid`, `m_sop`, `m_eop`, `busy`, `done`: 0.
  - `m_data` 0, `frame_cnt` 0.
- Cycle sequence from `start` sampled high at edge 0:
  - PRIME in cycle 1.
  - RUN from cycle 2, so `s_ready` can first be 1 in cycle 2.
- Latency: 1 cycle, from acc at edge t to `m_valid` in cycle t+1.
- Minimum frame time with continuous `s_valid` and `m_ready` = 1: N+2 cycles from `start` to `done`.
- Backpressure: `m_ready` low with `m_valid` high forces `s_ready` low in the same cycle. k and `coef_idx` hold, so `coef` stays aligned.
- `s_valid` gaps are allowed: k and `coef_idx` are stable and no output is produced.
- Reset asserted mid-frame forces all reset values immediately (asynchronous).

## Test plan
- **Constant 1000, continuous valid/ready, coef model = hann32 values:**
  - idx0 → 0, idx1 → 10, idx8 → 500, idx16 → 1000.
  - `m_sop` only on idx0, `m_eop` only on idx31.
  - `done` in cycle 34 after `start`; `frame_cnt` = 1.
- **Sample −2048 at idx16 (coef 2047):**
  - `m_data` = −2047.
  - Sample 2047 at idx16 → 2046.
- **`m_ready` toggled 1/0 every cycle, `s_valid` random 50%:**
  - Output sequence bit-identical to the unstalled run.
  - Never two acc in a cycle with `m_valid` && !`m_ready`.
- **`abort` asserted at k = 12:**
  - Cycle after: IDLE, `m_valid` 0, no `done`, `frame_cnt` unchanged.
  - Next `start` yields a full correct frame starting at idx0.
- **Busy and simultaneous requests:**
  - `start` pulsed during RUN and on the `done` cycle: both ignored, exactly one frame counted.
  - `start` and `abort` together in IDLE: stays IDLE.
- **Counter wrap and reset mid-frame:**
  - 256 back-to-back frames → `frame_cnt` wraps to 0.
  - `rst` mid-frame → all outputs at reset values within the same cycle.
